// File: rtl/whack_pkg.sv
// whack_pkg: shared types and helpers for the whack-a-mole round sequencer.
// Mole codes, FSM state encoding and the whack-key compare.
package whack_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    SHOW,
    HIT,
    MISS,
    PAUSE,
    LOSE
  } state_e;

  localparam logic [2:0] MOLE_W = 3'd1;
  localparam logic [2:0] MOLE_A = 3'd2;
  localparam logic [2:0] MOLE_S = 3'd3;
  localparam logic [2:0] MOLE_D = 3'd4;
  localparam logic [2:0] MOLE_X = 3'd5;

  // key vector order is {X, D, S, A, W}
  function automatic logic [4:0] mole_mask(input logic [2:0] code);
    logic [4:0] m;
    m = 5'b00000;
    case (code)
      MOLE_W:  m = 5'b00001;
      MOLE_A:  m = 5'b00010;
      MOLE_S:  m = 5'b00100;
      MOLE_D:  m = 5'b01000;
      MOLE_X:  m = 5'b10000;
      default: m = 5'b00000;
    endcase
    return m;
  endfunction

  // returns {wrong, right} for the key edges against a mole code
  function automatic logic [1:0] key_match(
    input logic [4:0] edges,
    input logic [2:0] code
  );
    logic [4:0] m;
    m = mole_mask(code);
    return {|(edges & ~m), |(edges & m)};
  endfunction

endpackage

// File: rtl/whack_mole_lfsr.sv
// whack_mole_lfsr: free-running 8-bit LFSR and mole code picker.
// Never repeats the previous code and never yields 0, 6 or 7.
module whack_mole_lfsr
  import whack_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] prev_code,
  output logic [2:0] next_code
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic [2:0] idx;
  logic [2:0] base;

  // Fibonacci step, taps 8,6,5,4
  always_comb begin
    lfsr_d = {lfsr_q[6:0],
              lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // advance every clock so timing of the player adds entropy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // fold 0..7 into 0..4, map to 1..5, skip the previous code
  always_comb begin
    idx = lfsr_q[2:0];
    if (idx >= 3'd5) begin
      idx = idx - 3'd5;
    end
    base = idx + 3'd1;
    next_code = base;
    if (base == prev_code) begin
      next_code = (base == MOLE_X) ? MOLE_W : base + 3'd1;
    end
  end

endmodule

// File: rtl/whack_round_ctrl.sv
// whack_round_ctrl: round sequencer for the whack-a-mole game.
// Times the mole window, classifies hit/miss, keeps score and pause.
module whack_round_ctrl
  import whack_pkg::*;
#(
  parameter int         TICK_DIV   = 50_000_000,
  parameter int         SHOW_TICKS = 2,
  parameter int         GAP_TICKS  = 1,
  parameter int         MAX_MISSES = 3,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_esc,
  input  logic       key_space,
  input  logic       A,
  input  logic       W,
  input  logic       S,
  input  logic       D,
  input  logic       X,
  output logic [2:0] mole_pos,
  output logic       mole_valid,
  output logic [3:0] score,
  output logic [1:0] misses,
  output logic       game_lose,
  output logic       paused,
  output logic       hit_pulse,
  output logic       led
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PSC_TOP = PW'(TICK_DIV - 1);
  localparam logic [7:0] GAP_TOP  = 8'(GAP_TICKS - 1);
  localparam logic [7:0] SHOW_TOP = 8'(SHOW_TICKS - 1);
  localparam logic [1:0] MISS_TOP = 2'(MAX_MISSES);

  state_e        state_q;
  state_e        ret_q;
  logic [PW-1:0] psc_q;
  logic [PW-1:0] psc_d;
  logic [7:0]    tcnt_q;
  logic [3:0]    score_q;
  logic [1:0]    misses_q;
  logic [1:0]    misses_d;
  logic [2:0]    last_q;
  logic [2:0]    pos_q;
  logic          valid_q;
  logic          lose_q;
  logic          paused_q;
  logic          hit_q;
  logic          led_q;
  logic [4:0]    key_prev_q;
  logic          space_prev_q;

  logic [4:0] keys;
  logic [4:0] key_edge;
  logic       space_edge;
  logic       tick;
  logic       wrong;
  logic       right;
  logic [2:0] next_code;

  whack_mole_lfsr #(
    .LFSR_SEED(LFSR_SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .prev_code(last_q),
    .next_code(next_code)
  );

  // key edges, prescaler step and whack classification
  always_comb begin
    keys       = {X, D, S, A, W};
    key_edge   = keys & ~key_prev_q;
    space_edge = key_space & ~space_prev_q;
    tick       = (psc_q == PSC_TOP);
    psc_d      = tick ? '0 : psc_q + PW'(1);
    {wrong, right} = key_match(key_edge, pos_q);
    misses_d   = misses_q + 2'd1;
  end

  // round FSM with timers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ret_q        <= IDLE;
      psc_q        <= '0;
      tcnt_q       <= '0;
      score_q      <= '0;
      misses_q     <= '0;
      last_q       <= '0;
      pos_q        <= '0;
      valid_q      <= 1'b0;
      lose_q       <= 1'b0;
      paused_q     <= 1'b0;
      hit_q        <= 1'b0;
      led_q        <= 1'b0;
      key_prev_q   <= '0;
      space_prev_q <= 1'b0;
    end else begin
      key_prev_q   <= keys;
      space_prev_q <= key_space;
      hit_q        <= 1'b0;
      if (key_esc) begin
        state_q  <= IDLE;
        psc_q    <= '0;
        tcnt_q   <= '0;
        score_q  <= '0;
        misses_q <= '0;
        pos_q    <= '0;
        valid_q  <= 1'b0;
        lose_q   <= 1'b0;
        paused_q <= 1'b0;
        led_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (space_edge) begin
              state_q <= GAP;
              psc_q   <= '0;
              tcnt_q  <= '0;
            end
          end
          GAP: begin
            if (space_edge) begin
              ret_q    <= GAP;
              state_q  <= PAUSE;
              paused_q <= 1'b1;
            end else begin
              psc_q <= psc_d;
              if (tick) begin
                led_q <= 1'b0;
                if (tcnt_q == GAP_TOP) begin
                  state_q <= SHOW;
                  tcnt_q  <= '0;
                  pos_q   <= next_code;
                  last_q  <= next_code;
                  valid_q <= 1'b1;
                end else begin
                  tcnt_q <= tcnt_q + 8'd1;
                end
              end
            end
          end
          SHOW: begin
            if (space_edge) begin
              ret_q    <= SHOW;
              state_q  <= PAUSE;
              paused_q <= 1'b1;
              valid_q  <= 1'b0;
            end else if (wrong) begin
              state_q <= MISS;
              pos_q   <= '0;
              valid_q <= 1'b0;
            end else if (right) begin
              state_q <= HIT;
              pos_q   <= '0;
              valid_q <= 1'b0;
            end else begin
              psc_q <= psc_d;
              if (tick) begin
                led_q <= 1'b0;
                if (tcnt_q == SHOW_TOP) begin
                  state_q <= MISS;
                  pos_q   <= '0;
                  valid_q <= 1'b0;
                end else begin
                  tcnt_q <= tcnt_q + 8'd1;
                end
              end
            end
          end
          HIT: begin
            if (score_q != 4'hF) begin
              score_q <= score_q + 4'd1;
            end
            hit_q   <= 1'b1;
            led_q   <= 1'b1;
            state_q <= GAP;
            psc_q   <= '0;
            tcnt_q  <= '0;
          end
          MISS: begin
            misses_q <= misses_d;
            psc_q    <= '0;
            tcnt_q   <= '0;
            if (misses_d == MISS_TOP) begin
              lose_q  <= 1'b1;
              state_q <= LOSE;
            end else begin
              state_q <= GAP;
            end
          end
          PAUSE: begin
            if (space_edge) begin
              state_q  <= ret_q;
              paused_q <= 1'b0;
              valid_q  <= (ret_q == SHOW);
            end
          end
          LOSE: begin
            state_q <= LOSE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign mole_pos   = pos_q;
  assign mole_valid = valid_q;
  assign score      = score_q;
  assign misses     = misses_q;
  assign game_lose  = lose_q;
  assign paused     = paused_q;
  assign hit_pulse  = hit_q;
  assign led        = led_q;

endmodule
